// File: rtl/vend_payout_ctrl_if.sv
// Request/actuator bundle between the soda dispenser FSM, the refill
// sensors and the payout controller. The dispenser side is the master
// (drives strobes, reads actuator/status), the controller is the slave.
interface vend_payout_ctrl_if #(
    parameter int CNT_W = 6
);
    logic             dis;
    logic             rn;
    logic             rd;
    logic             rtd;
    logic             refill_n;
    logic             refill_d;
    logic             vend_sol;
    logic             nick_eject;
    logic             dime_eject;
    logic             busy;
    logic [CNT_W-1:0] n_count;
    logic [CNT_W-1:0] d_count;
    logic             exact_change;
    logic             short_err;

    modport master (
        output dis, rn, rd, rtd, refill_n, refill_d,
        input  vend_sol, nick_eject, dime_eject, busy,
               n_count, d_count, exact_change, short_err
    );

    modport slave (
        input  dis, rn, rd, rtd, refill_n, refill_d,
        output vend_sol, nick_eject, dime_eject, busy,
               n_count, d_count, exact_change, short_err
    );
endinterface

// File: rtl/vend_payout_ctrl.sv
// Payout controller: queues single-cycle vend/coin-return strobes and plays
// them out as timed, non-overlapping actuator pulses (vend, nickel, dime),
// each followed by a mandatory off-time. Tracks coin tube inventory.
module vend_payout_ctrl #(
    parameter int PULSE_LEN   = 4,
    parameter int GAP_LEN     = 2,
    parameter int CNT_W       = 6,
    parameter int NICKEL_INIT = 20,
    parameter int DIME_INIT   = 20
) (
    input  logic             clk,
    input  logic             reset,
    vend_payout_ctrl_if.slave bus
);

    localparam int TMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0]    PULSE_LOAD = TW'(PULSE_LEN - 1);
    localparam logic [TW-1:0]    GAP_LOAD   = TW'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] N_INIT     = CNT_W'(NICKEL_INIT);
    localparam logic [CNT_W-1:0] D_INIT     = CNT_W'(DIME_INIT);

    typedef enum logic [2:0] {
        IDLE,
        VEND_ON,
        NICK_ON,
        DIME_ON,
        GAP
    } state_t;

    state_t           state_q;
    logic [TW-1:0]    timer_q;
    logic             vendSol_q;
    logic             nickEject_q;
    logic             dimeEject_q;
    logic             shortErr_q;

    logic             pendV_q, pendV_d;
    logic             pendN_q, pendN_d;
    logic [1:0]       pendD_q, pendD_d;
    logic [CNT_W-1:0] nCount_q, nCount_d;
    logic [CNT_W-1:0] dCount_q, dCount_d;

    logic             serviceNow;
    logic             pickVend;
    logic             pickNick;
    logic             pickDime;
    logic             payNick;
    logic             payDime;
    logic [2:0]       pendDSum;

    // Decide which queued request is taken this edge; the end of a gap
    // chains straight into the next request without an idle cycle.
    always_comb begin
        serviceNow = (state_q == IDLE) || ((state_q == GAP) && (timer_q == '0));
        pickVend   = serviceNow & pendV_q;
        pickNick   = serviceNow & ~pendV_q & pendN_q;
        pickDime   = serviceNow & ~pendV_q & ~pendN_q & (pendD_q != 2'd0);
        payNick    = pickNick & (nCount_q != '0);
        payDime    = pickDime & (dCount_q != '0);
    end

    // Request queue: new strobes are merged every cycle, taken requests
    // are retired; the dime count saturates at three.
    always_comb begin
        pendV_d  = (pendV_q & ~pickVend) | bus.dis;
        pendN_d  = (pendN_q & ~pickNick) | bus.rn;
        pendDSum = {1'b0, pendD_q} - {2'b00, pickDime}
                 + {2'b00, bus.rd} + {1'b0, bus.rtd, 1'b0};
        pendD_d  = (pendDSum > 3'd3) ? 2'd3 : pendDSum[1:0];
    end

    // Tube inventory: a refill and a payout in the same cycle cancel;
    // refills stop at full scale, payouts only happen on a non-empty tube.
    always_comb begin
        nCount_d = nCount_q;
        if (bus.refill_n && !payNick) begin
            nCount_d = (nCount_q == CNT_MAX) ? CNT_MAX : nCount_q + CNT_W'(1);
        end else if (!bus.refill_n && payNick) begin
            nCount_d = nCount_q - CNT_W'(1);
        end

        dCount_d = dCount_q;
        if (bus.refill_d && !payDime) begin
            dCount_d = (dCount_q == CNT_MAX) ? CNT_MAX : dCount_q + CNT_W'(1);
        end else if (!bus.refill_d && payDime) begin
            dCount_d = dCount_q - CNT_W'(1);
        end
    end

    // Queue and inventory registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pendV_q  <= 1'b0;
            pendN_q  <= 1'b0;
            pendD_q  <= 2'd0;
            nCount_q <= N_INIT;
            dCount_q <= D_INIT;
        end else begin
            pendV_q  <= pendV_d;
            pendN_q  <= pendN_d;
            pendD_q  <= pendD_d;
            nCount_q <= nCount_d;
            dCount_q <= dCount_d;
        end
    end

    // Pulse sequencer with registered actuator drives and sticky shortfall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            vendSol_q   <= 1'b0;
            nickEject_q <= 1'b0;
            dimeEject_q <= 1'b0;
            shortErr_q  <= 1'b0;
        end else if (serviceNow) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            vendSol_q   <= 1'b0;
            nickEject_q <= 1'b0;
            dimeEject_q <= 1'b0;
            if (pickVend) begin
                state_q   <= VEND_ON;
                timer_q   <= PULSE_LOAD;
                vendSol_q <= 1'b1;
            end else if (payNick) begin
                state_q     <= NICK_ON;
                timer_q     <= PULSE_LOAD;
                nickEject_q <= 1'b1;
            end else if (payDime) begin
                state_q     <= DIME_ON;
                timer_q     <= PULSE_LOAD;
                dimeEject_q <= 1'b1;
            end
            if ((pickNick && !payNick) || (pickDime && !payDime)) begin
                shortErr_q <= 1'b1;
            end
        end else begin
            case (state_q)
                VEND_ON, NICK_ON, DIME_ON: begin
                    if (timer_q == '0) begin
                        state_q     <= GAP;
                        timer_q     <= GAP_LOAD;
                        vendSol_q   <= 1'b0;
                        nickEject_q <= 1'b0;
                        dimeEject_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                GAP: begin
                    timer_q <= timer_q - TW'(1);
                end
                default: begin
                    state_q <= IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign bus.vend_sol     = vendSol_q;
    assign bus.nick_eject   = nickEject_q;
    assign bus.dime_eject   = dimeEject_q;
    assign bus.short_err    = shortErr_q;
    assign bus.n_count      = nCount_q;
    assign bus.d_count      = dCount_q;
    assign bus.busy         = (state_q != IDLE) | pendV_q | pendN_q | (pendD_q != 2'd0);
    assign bus.exact_change = (nCount_q == '0) | (dCount_q < CNT_W'(2));

endmodule
